// File: rtl/regfl_pkg.sv
// Shared constants and helpers for the register-file write arbiter.
package regfl_pkg;

    localparam int unsigned AW        = 3;
    localparam int unsigned DW        = 64;
    localparam int unsigned NREG      = 8;
    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned IDXW      = 3;

    // One-hot (or zero) to binary index; zero maps to index 0.
    function automatic logic [IDXW-1:0] oh2idx(input logic [NREG-1:0] oh);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (oh[i]) idx = idx | IDXW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfl_wr_arb_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searched upward from a
// registered pointer, pointer advances past the winner on acceptance.
module rr_arb
    import regfl_pkg::*;
#(
    parameter int unsigned N = N_REQ_DEF
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = $clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    // N is a power of two, so pointer arithmetic wraps naturally.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        if (en) begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = ptr_q + PW'(k);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en && (|req)) begin
            ptr_d = PW'(oh2idx(NREG'(gnt))) + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfl_wr_arb.sv
// Write-port arbiter for the 8 x 64 register file: round-robin grant,
// one-cycle registered write port, written-scoreboard and saturating counter.
module regfl_wr_arb
    import regfl_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned CW    = 16
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                frz,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdat,
    output logic [N_REQ-1:0]    gnt,
    input  logic [NREG-1:0]     inv,
    output logic                we,
    output logic [AW-1:0]       s,
    output logic [DW-1:0]       d,
    output logic [NREG-1:0]     vld,
    output logic [CW-1:0]       wr_cnt,
    output logic                busy
);

    logic            we_q,  we_d;
    logic [AW-1:0]   s_q,   s_d;
    logic [DW-1:0]   d_q,   d_d;
    logic [NREG-1:0] vld_q, vld_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_dat;

    rr_arb #(.N(N_REQ)) u_arb (
        .clk   (clk),
        .rst_b (rst_b),
        .en    (~frz),
        .req   (req),
        .gnt   (gnt)
    );

    // Grant is one-hot, so an OR-mux picks the winner's address and data.
    always_comb begin
        sel_addr = '0;
        sel_dat  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = sel_addr | addr[i*AW +: AW];
                sel_dat  = sel_dat  | wdat[i*DW +: DW];
            end
        end
    end

    always_comb begin
        we_d  = |gnt;
        s_d   = s_q;
        d_d   = d_q;
        vld_d = vld_q & ~inv;
        cnt_d = cnt_q;
        if (|gnt) begin
            s_d = sel_addr;
            d_d = sel_dat;
        end
        // A write landing this edge beats a clear of the same register.
        if (we_q) begin
            vld_d[s_q] = 1'b1;
            if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            we_q  <= 1'b0;
            s_q   <= '0;
            d_q   <= '0;
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            we_q  <= we_d;
            s_q   <= s_d;
            d_q   <= d_d;
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    assign we     = we_q;
    assign s      = s_q;
    assign d      = d_q;
    assign vld    = vld_q;
    assign wr_cnt = cnt_q;
    assign busy   = (|req) & ~frz;

endmodule

// File: tb/tb_regfl_wr_arb.sv
// Bench for regfl_wr_arb: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_regfl_wr_arb;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         frz;
    logic [3:0]   req;
    logic [11:0]  addr;
    logic [255:0] wdat;
    logic [7:0]   inv;
    logic [3:0]   gnt,  gnt2;
    logic         we,   we2;
    logic [2:0]   s,    s2;
    logic [63:0]  d,    d2;
    logic [7:0]   vld,  vld2;
    logic [15:0]  wr_cnt;
    logic [2:0]   wr_cnt2;
    logic         busy, busy2;

    int n_pass = 0;
    int n_tot  = 0;

    regfl_wr_arb dut (
        .clk(clk), .rst_b(rst_b), .frz(frz), .req(req), .addr(addr), .wdat(wdat),
        .gnt(gnt), .inv(inv), .we(we), .s(s), .d(d), .vld(vld), .wr_cnt(wr_cnt), .busy(busy)
    );

    // Narrow-counter copy to reach saturation quickly.
    regfl_wr_arb #(.N_REQ(4), .CW(3)) dut_sat (
        .clk(clk), .rst_b(rst_b), .frz(frz), .req(req), .addr(addr), .wdat(wdat),
        .gnt(gnt2), .inv(inv), .we(we2), .s(s2), .d(d2), .vld(vld2), .wr_cnt(wr_cnt2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Behavioural model: pointer as an integer, one pending write, a bit array and counts.
    int          m_ptr  = 0;
    logic        m_we   = 1'b0;
    logic [2:0]  m_s    = '0;
    logic [63:0] m_d    = '0;
    logic [7:0]  m_vld  = '0;
    int          m_cnt  = 0;
    int          m_cnt2 = 0;

    function automatic int pick(input int ptr, input logic [3:0] r, input logic f);
        if (f || r == 4'b0) return -1;
        for (int k = 0; k < 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_b) begin
        int         g;
        logic [7:0] nv;
        if (!rst_b) begin
            m_ptr <= 0; m_we <= 1'b0; m_s <= '0; m_d <= '0;
            m_vld <= '0; m_cnt <= 0; m_cnt2 <= 0;
        end else begin
            g  = pick(m_ptr, req, frz);
            nv = m_vld & ~inv;
            if (m_we) begin
                nv[m_s] = 1'b1;
                if (m_cnt  < 65535) m_cnt  <= m_cnt + 1;
                if (m_cnt2 < 7)     m_cnt2 <= m_cnt2 + 1;
            end
            m_vld <= nv;
            if (g >= 0) begin
                m_we  <= 1'b1;
                m_s   <= addr[g*3 +: 3];
                m_d   <= wdat[g*64 +: 64];
                m_ptr <= (g + 1) % 4;
            end else begin
                m_we <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int         g;
        logic [3:0] eg;
        g  = pick(m_ptr, req, frz);
        eg = (g >= 0) ? 4'(1 << g) : 4'b0;
        chk("m_gnt",  64'(gnt),     64'(eg));
        chk("m_busy", 64'(busy),    64'((req != 4'b0) && !frz));
        chk("m_we",   64'(we),      64'(m_we));
        chk("m_s",    64'(s),       64'(m_s));
        chk("m_d",    d,            m_d);
        chk("m_vld",  64'(vld),     64'(m_vld));
        chk("m_cnt",  64'(wr_cnt),  64'(m_cnt));
        chk("m_cnt2", 64'(wr_cnt2), 64'(m_cnt2));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_b = 1'b0; frz = 1'b0; req = '0; addr = '0; wdat = '0; inv = '0;
        @(negedge clk);
        chk("rst_we",  64'(we),     64'd0);
        chk("rst_vld", 64'(vld),    64'd0);
        chk("rst_cnt", 64'(wr_cnt), 64'd0);
        chk("rst_gnt", 64'(gnt),    64'd0);
        tick();
        rst_b = 1'b1;

        // Single write from requester 0
        req = 4'b0001; addr[2:0] = 3'd5; wdat[63:0] = 64'd1;
        @(negedge clk); chk("t1_gnt", 64'(gnt), 64'h1);
        tick(); req = '0;
        @(negedge clk);
        chk("t1_we", 64'(we), 64'd1); chk("t1_s", 64'(s), 64'd5); chk("t1_d", d, 64'd1);
        tick();
        @(negedge clk);
        chk("t1_vld", 64'(vld), 64'h20); chk("t1_cnt", 64'(wr_cnt), 64'd1);

        // All four requesting for eight cycles
        tick(); rst_b = 1'b0;
        tick(); rst_b = 1'b1;
        addr = {3'd3, 3'd2, 3'd1, 3'd0}; req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t2_gnt", 64'(gnt), 64'(1 << (k % 4)));
            if (k > 0) chk("t2_we", 64'(we), 64'd1);
            tick();
        end
        req = '0;
        @(negedge clk); chk("t2_we_last", 64'(we), 64'd1);
        tick();
        @(negedge clk);
        chk("t2_vld", 64'(vld), 64'h0F); chk("t2_cnt", 64'(wr_cnt), 64'd8);
        chk("t2_we_off", 64'(we), 64'd0);

        // Wrap from requester 3 to 0
        tick(); req = 4'b0100;
        @(negedge clk); chk("t3_gnt2", 64'(gnt), 64'h4);
        tick(); req = 4'b0101;
        @(negedge clk); chk("t3_gnt0", 64'(gnt), 64'h1);
        tick();
        @(negedge clk); chk("t3_gnt2b", 64'(gnt), 64'h4);
        tick(); req = '0;

        // Clear mask colliding with a write
        tick(); req = 4'b0010;
        tick(); req = '0; inv = 8'h03;
        @(negedge clk); chk("t4_we", 64'(we), 64'd1); chk("t4_s", 64'(s), 64'd1);
        tick(); inv = '0;
        @(negedge clk); chk("t4_vld", 64'(vld), 64'h0E);

        // Freeze
        tick(); frz = 1'b1; req = 4'b0010;
        repeat (3) begin
            @(negedge clk);
            chk("t5_gnt_frz", 64'(gnt), 64'd0); chk("t5_busy_frz", 64'(busy), 64'd0);
            tick();
        end
        frz = 1'b0;
        @(negedge clk); chk("t5_gnt", 64'(gnt), 64'h2); chk("t5_busy", 64'(busy), 64'd1);
        tick(); req = '0;
        @(negedge clk); chk("t5_we", 64'(we), 64'd1); chk("t5_s", 64'(s), 64'd1);

        // Reset right after an acceptance
        tick(); req = 4'b0001;
        tick(); rst_b = 1'b0; req = '0;
        #1;
        chk("t6_we_async", 64'(we), 64'd0); chk("t6_vld_async", 64'(vld), 64'd0);
        @(negedge clk); chk("t6_we_rst", 64'(we), 64'd0);
        tick(); rst_b = 1'b1;
        @(negedge clk); chk("t6_we_after", 64'(we), 64'd0);
        tick(); req = 4'b1111;
        @(negedge clk); chk("t6_ptr0", 64'(gnt), 64'h1);
        tick(); req = '0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            req  = 4'($urandom);
            frz  = ($urandom_range(7) == 0);
            inv  = ($urandom_range(5) == 0) ? 8'($urandom) : 8'h00;
            addr = 12'($urandom);
            for (int w = 0; w < 8; w++) wdat[w*32 +: 32] = $urandom;
        end
        tick(); req = '0; frz = 1'b0; inv = '0;
        @(negedge clk);
        chk("end_sat2", 64'(wr_cnt2), 64'd7);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/regfl_wr_arb.md
Name: regfl_wr_arb

Overview:
- Round-robin arbiter and write sequencer sharing the single write port of the 8 x 64-bit register file (we / s / d interface) between N_REQ requesters.
- Grants one request per cycle, registers the winning address/data onto the register-file write port, and keeps a per-register "written" scoreboard plus a saturating write counter for status and debug.
- Sits between the producing units and the register file; the register file itself is unchanged.

Parameters:
N_REQ, 4, number of requesters (power of two, 2..8)
AW, 3, register address width (NREG = 2**AW = 8)
DW, 64, data width
CW, 16, width of the write counter

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  asynchronous active-low reset
frz  in  1  freeze: no grants issued while high
req  in  N_REQ  per-requester write request
addr  in  N_REQ*AW  packed addresses; requester i at [i*AW +: AW]
wdat  in  N_REQ*DW  packed data; requester i at [i*DW +: DW]
gnt  out  N_REQ  one-hot grant, combinational, same cycle as req
inv  in  2**AW  scoreboard clear mask, one-cycle pulse
we  out  1  register-file write enable, registered
s  out  AW  register-file select, registered
d  out  DW  register-file write data, registered
vld  out  2**AW  scoreboard: bit r = register r written since last clear
wr_cnt  out  CW  saturating count of committed writes
busy  out  1  high when any req bit is high and frz is low

Behaviour:
- Reset, asynchronous while rst_b = 0: we = 0, s = 0, d = 0, vld = 0, wr_cnt = 0, priority pointer ptr = 0. Any write already latched but not yet issued is discarded.
- Arbitration is combinational:
  - If frz = 1 or req = 0, then gnt = 0.
  - Otherwise gnt selects the first set req bit, searching from index ptr upward and wrapping modulo N_REQ.
  - gnt is always one-hot or zero.
- Acceptance: at a rising edge where gnt[i] = 1, requester i's request is consumed. The requester must drop or change req[i] in the next cycle if it has no further write.
- Pointer update: on acceptance, ptr <= (i + 1) mod N_REQ. With no acceptance, ptr holds.
- Write port latency is 1 cycle:
  - The edge that accepts requester i loads we <= 1, s <= addr_i, d <= wdat_i.
  - These values are presented to the register file during the following cycle, and the register file captures them on the next edge.
  - With no acceptance, we <= 0. s and d hold their last values.
- Back-to-back: one write can be accepted per cycle, so we can stay high for consecutive cycles.
- Address conflict: multiple requesters may target the same register. Writes are issued in grant order, so the last grant wins in the register file.
- Scoreboard vld, updated at the edge where we = 1:
  - vld[s] <= 1.
  - Every other bit r is cleared when inv[r] = 1.
  - If inv[s] and a write to s occur at the same edge, set wins.
  - When we = 0, vld <= vld & ~inv.
- wr_cnt increments at each edge where we = 1 and saturates at 2**CW - 1 (no wrap).
- frz asserted mid-stream: an already-latched write still issues (we stays high for that one cycle), and no new grants are given. When frz is released, arbitration resumes from the held ptr.
- Fairness: a continuously asserted requester is granted within N_REQ accepted grants.
- No X may propagate to gnt when req = 0.

Decomposition:
- Shared package regfl_pkg holds:
  - constants AW = 3, DW = 64, NREG = 8;
  - the default N_REQ = 4;
  - a function for the one-hot-to-index encode.
- One sub-module, rr_arb (parameter N). It contains:
  - inputs clk, rst_b, en, req[N], and a registered ptr;
  - output gnt[N] one-hot;
  - ptr update on en & |req.
- regfl_wr_arb instantiates rr_arb and contains the write-port registers, the scoreboard and the counter.

Test Plan:
1. Reset, then req = 4'b0001, addr0 = 5, wdat0 = 64'd1 for one cycle. Required: gnt = 0001 that cycle; next cycle we = 1, s = 5, d = 1; after that edge vld = 8'h20 and wr_cnt = 1.
2. req = 4'b1111 held for 8 cycles, addr_i = i. Required: grants in order 0, 1, 2, 3, 0, 1, 2, 3; we high 8 consecutive cycles; vld = 8'h0F; wr_cnt = 8.
3. After accepting requester 2, req = 4'b0101. Required: next grant goes to requester 0 (ptr = 3 wraps past 3 to 0), then requester 2.
4. Scoreboard: vld = 8'h0F, then inv = 8'h03 pulsed in the same cycle that we = 1 with s = 1. Required: vld = 8'h0E (bit 1 kept because set wins, bit 0 cleared).
5. frz = 1 with req = 4'b0010, then frz = 0 after 3 cycles. Required: gnt = 0 and busy = 0 during the freeze; a grant to requester 1 in the first unfrozen cycle, with we one cycle later.
6. Reset asserted the cycle after an acceptance (we about to issue). Required: we = 0 and vld = 0 immediately (asynchronous); no write is issued after rst_b returns high; ptr = 0.
